// File: rtl/gol_pkg.sv
// Shared constants and step-handshake state type for the Game of Life display path.
package gol_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int GRID_W   = 80;
   localparam int GRID_H   = 60;
   localparam int ADDR_W   = 13;

   typedef enum logic [1:0] {IDLE, REQ, DONE} step_state_t;
endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with a per-bit reset pattern.
module pipe_delay #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [DEPTH-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= {DEPTH{RESET_VAL}};
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];
endmodule

// File: rtl/gol_pixel_renderer.sv
// Maps VGA counters to cell RAM reads and RGB with syncs realigned to the read
// pipeline, and runs the once-per-frame step handshake with the update engine.
module gol_pixel_renderer
   import gol_pkg::*;
#(
   parameter int          CELL_SHIFT = 3,
   parameter logic [23:0] LIVE_RGB   = 24'h00FF00,
   parameter logic [23:0] DEAD_RGB   = 24'h000000,
   parameter logic [23:0] GRID_RGB   = 24'h202020,
   parameter bit          SHOW_GRID  = 1'b1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        counter_x,
   input  logic [9:0]        counter_y,
   input  logic              h_sync_in,
   input  logic              v_sync_in,
   input  logic              disp_en_in,
   output logic [ADDR_W-1:0] cell_addr,
   output logic              cell_rd_en,
   input  logic              cell_data,
   output logic [23:0]       rgb,
   output logic              h_sync_out,
   output logic              v_sync_out,
   output logic              blank_n_out,
   input  logic              pause,
   output logic              step_req,
   input  logic              step_ack,
   output logic [7:0]        missed_steps
);
   logic [9:0]        col, row;
   logic [ADDR_W-1:0] lin_addr;
   logic              in_active, on_grid, grid_a, grid_b, disp_d;
   logic [2:0]        sync_q;

   assign col       = counter_x >> CELL_SHIFT;
   assign row       = counter_y >> CELL_SHIFT;
   // row*80 as row*64 + row*16
   assign lin_addr  = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
   assign in_active = (counter_x < 10'(H_ACTIVE)) && (counter_y < 10'(V_ACTIVE));
   assign on_grid   = SHOW_GRID && (counter_x[CELL_SHIFT-1:0] == '0 ||
                                    counter_y[CELL_SHIFT-1:0] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cell_addr  <= '0;
         cell_rd_en <= 1'b0;
         grid_a     <= 1'b0;
      end else begin
         cell_addr  <= in_active ? lin_addr : '0;
         cell_rd_en <= in_active;
         grid_a     <= on_grid;
      end
   end

   // disp_en already lags one cycle, so one more stage lines it up with cell_data
   pipe_delay #(.WIDTH(2), .DEPTH(1), .RESET_VAL(2'b00)) u_flag_dly (
      .clk(clk), .rst_n(rst_n), .d({disp_en_in, grid_a}), .q({disp_d, grid_b}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rgb <= '0;
      else if (!disp_d)  rgb <= '0;
      else if (grid_b)   rgb <= GRID_RGB;
      else if (cell_data) rgb <= LIVE_RGB;
      else               rgb <= DEAD_RGB;
   end

   // blank_n travels with the syncs so it resets low while the syncs reset high
   pipe_delay #(.WIDTH(3), .DEPTH(2), .RESET_VAL(3'b110)) u_sync_dly (
      .clk(clk), .rst_n(rst_n), .d({h_sync_in, v_sync_in, h_sync_in & v_sync_in}), .q(sync_q));

   assign h_sync_out  = sync_q[2];
   assign v_sync_out  = sync_q[1];
   assign blank_n_out = sync_q[0];

   step_state_t state, state_nx;
   logic        vblank_start, frame_wrap, miss;

   assign vblank_start = (counter_x == '0) && (counter_y == 10'(V_ACTIVE));
   assign frame_wrap   = (counter_x == '0) && (counter_y == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      miss     = 1'b0;
      case (state)
         IDLE: if (vblank_start && !pause) state_nx = REQ;
         REQ: begin
            if (step_ack) begin
               state_nx = frame_wrap ? IDLE : DONE;
            end else if (frame_wrap) begin
               state_nx = IDLE;
               miss     = 1'b1;
            end
         end
         DONE:    if (frame_wrap) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      step_req = (state == REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            missed_steps <= '0;
      else if (miss && missed_steps != 8'hFF) missed_steps <= missed_steps + 8'd1;
   end
endmodule

// File: tb/tb_gol_pixel_renderer.sv
// Randomized bench for gol_pixel_renderer against a coordinate-level reference model.
module tb_gol_pixel_renderer;
   localparam logic [23:0] LIVE = 24'h00FF00;
   localparam logic [23:0] DEAD = 24'h000000;
   localparam logic [23:0] GRID = 24'h202020;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic [9:0]  counter_x = 10'd780, counter_y = 10'd500;
   logic        h_sync_in = 1'b1, v_sync_in = 1'b1, disp_en_in = 1'b0;
   logic        pause = 1'b0, step_ack = 1'b0;
   logic [12:0] cell_addr, addr_ng;
   logic        cell_rd_en, rd_ng;
   logic        cell_data = 1'b0, data_ng = 1'b0;
   logic [23:0] rgb, rgb_ng;
   logic        h_sync_out, v_sync_out, blank_n_out, hs_ng, vs_ng, bn_ng;
   logic        step_req, req_ng;
   logic [7:0]  missed_steps, missed_ng;

   gol_pixel_renderer dut (
      .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_en_in(disp_en_in),
      .cell_addr(cell_addr), .cell_rd_en(cell_rd_en), .cell_data(cell_data),
      .rgb(rgb), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .blank_n_out(blank_n_out),
      .pause(pause), .step_req(step_req), .step_ack(step_ack), .missed_steps(missed_steps));

   gol_pixel_renderer #(.SHOW_GRID(1'b0)) dut_ng (
      .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_en_in(disp_en_in),
      .cell_addr(addr_ng), .cell_rd_en(rd_ng), .cell_data(data_ng),
      .rgb(rgb_ng), .h_sync_out(hs_ng), .v_sync_out(vs_ng), .blank_n_out(bn_ng),
      .pause(pause), .step_req(req_ng), .step_ack(step_ack), .missed_steps(missed_ng));

   bit mem [0:8191];

   always @(posedge clk) begin
      if (cell_rd_en) cell_data <= mem[cell_addr];
      if (rd_ng)      data_ng   <= mem[addr_ng];
   end

   typedef struct { int x; int y; logic [23:0] rgb_g; logic [23:0] rgb_n; logic hs; logic vs; } exp_t;
   exp_t pq[$];

   int checks = 0, errors = 0;
   int px = 799, py = 524;
   bit addr_valid = 0;
   int exp_addr = 0;
   bit exp_rd = 0;
   int phase = 0;          // 0 waiting for vblank, 1 requesting, 2 served this frame
   int exp_missed = 0;
   int live_seen_ng = 0;
   logic obs_hs, obs_req, obs_rd;
   logic [12:0] obs_addr;
   logic [7:0]  obs_missed;

   function automatic bit act_f(int x, int y);  return x < 640 && y < 480;      endfunction
   function automatic bit hs_f(int x);          return !(x >= 657 && x < 753);  endfunction
   function automatic bit vs_f(int y);          return !(y >= 490 && y < 492);  endfunction
   function automatic int addr_f(int x, int y); return act_f(x, y) ? (y / 8) * 80 + x / 8 : 0; endfunction
   function automatic logic [23:0] pix_f(int x, int y, bit grid_on);
      if (!act_f(x, y)) return 24'h0;
      if (grid_on && (x % 8 == 0 || y % 8 == 0)) return GRID;
      return mem[addr_f(x, y)] ? LIVE : DEAD;
   endfunction

   // One pixel clock: check what is due, then drive the next coordinate.
   task automatic cyc(input int x, input int y, input bit p, input bit a);
      exp_t e;
      @(negedge clk);
      obs_hs = h_sync_out; obs_req = step_req; obs_missed = missed_steps;
      obs_addr = cell_addr; obs_rd = cell_rd_en;
      if (pq.size() == 3) begin
         e = pq.pop_front();
         checks += 5;
         if (rgb !== e.rgb_g) begin errors++; $display("FAIL rgb (%0d,%0d) got %h want %h", e.x, e.y, rgb, e.rgb_g); end
         if (rgb_ng !== e.rgb_n) begin errors++; $display("FAIL rgb_nogrid (%0d,%0d) got %h want %h", e.x, e.y, rgb_ng, e.rgb_n); end
         if (h_sync_out !== e.hs) begin errors++; $display("FAIL h_sync (%0d,%0d) got %b want %b", e.x, e.y, h_sync_out, e.hs); end
         if (v_sync_out !== e.vs) begin errors++; $display("FAIL v_sync (%0d,%0d) got %b want %b", e.x, e.y, v_sync_out, e.vs); end
         if (blank_n_out !== (e.hs & e.vs)) begin errors++; $display("FAIL blank_n (%0d,%0d) got %b want %b", e.x, e.y, blank_n_out, e.hs & e.vs); end
         if (rgb_ng === LIVE) live_seen_ng++;
      end
      if (addr_valid) begin
         checks += 2;
         if (cell_addr !== 13'(exp_addr)) begin errors++; $display("FAIL cell_addr got %0d want %0d", cell_addr, exp_addr); end
         if (cell_rd_en !== exp_rd) begin errors++; $display("FAIL cell_rd_en got %b want %b", cell_rd_en, exp_rd); end
      end
      checks += 2;
      if (step_req !== (phase == 1)) begin errors++; $display("FAIL step_req got %b want %b", step_req, phase == 1); end
      if (missed_steps !== 8'(exp_missed)) begin errors++; $display("FAIL missed_steps got %0d want %0d", missed_steps, exp_missed); end

      counter_x = 10'(x); counter_y = 10'(y);
      h_sync_in = hs_f(px); v_sync_in = vs_f(py); disp_en_in = act_f(px, py);
      pause = p; step_ack = a;
      pq.push_back('{x, y, pix_f(x, y, 1), pix_f(x, y, 0), hs_f(x), vs_f(y)});
      exp_addr = addr_f(x, y); exp_rd = act_f(x, y); addr_valid = 1;
      px = x; py = y;

      case (phase)
         0: if (x == 0 && y == 480 && !p) phase = 1;
         1: if (a) phase = (x == 0 && y == 0) ? 0 : 2;
            else if (x == 0 && y == 0) begin phase = 0; if (exp_missed < 255) exp_missed++; end
         default: if (x == 0 && y == 0) phase = 0;
      endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(780, 500, 0, 0);
   endtask

   task automatic model_reset();
      pq.delete(); addr_valid = 0; phase = 0; exp_missed = 0; px = 799; py = 524;
   endtask

   task automatic check_reset_vals(input string tag);
      checks += 8;
      if (rgb !== 24'h0)        begin errors++; $display("FAIL %s rgb got %h want 0", tag, rgb); end
      if (h_sync_out !== 1'b1)  begin errors++; $display("FAIL %s h_sync got %b want 1", tag, h_sync_out); end
      if (v_sync_out !== 1'b1)  begin errors++; $display("FAIL %s v_sync got %b want 1", tag, v_sync_out); end
      if (blank_n_out !== 1'b0) begin errors++; $display("FAIL %s blank_n got %b want 0", tag, blank_n_out); end
      if (step_req !== 1'b0)    begin errors++; $display("FAIL %s step_req got %b want 0", tag, step_req); end
      if (missed_steps !== 8'd0) begin errors++; $display("FAIL %s missed got %0d want 0", tag, missed_steps); end
      if (cell_addr !== 13'd0)  begin errors++; $display("FAIL %s cell_addr got %0d want 0", tag, cell_addr); end
      if (cell_rd_en !== 1'b0)  begin errors++; $display("FAIL %s cell_rd_en got %b want 0", tag, cell_rd_en); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_live_cell();
      idle(3);
      for (int i = 0; i < 8192; i++) mem[i] = 0;
      mem[81] = 1;
      live_seen_ng = 0;
      for (int y = 0; y < 24; y++)
         for (int x = 0; x < 24; x++) cyc(x, y, 0, 0);
      idle(3);
      checks++;
      if (live_seen_ng != 64) begin errors++; $display("FAIL live_pixel_count got %0d want 64", live_seen_ng); end
   endtask

   task automatic test_grid();
      idle(3);
      for (int i = 0; i < 8192; i++) mem[i] = 1;
      cyc(16, 3, 0, 0); cyc(17, 3, 0, 0); cyc(639, 479, 0, 0);
      cyc(780, 500, 0, 0);
      checks++;
      if (obs_addr !== 13'd4799) begin errors++; $display("FAIL addr_639_479 got %0d want 4799", obs_addr); end
      for (int i = 0; i < 200; i++) cyc($urandom_range(0, 639), $urandom_range(0, 479), 0, 0);
      idle(3);
   endtask

   task automatic test_blank_sync();
      int k657, klow, k;
      repeat (4) cyc(700, 300, 0, 0);
      checks += 2;
      if (obs_addr !== 13'd0) begin errors++; $display("FAIL blank_addr got %0d want 0", obs_addr); end
      if (obs_rd !== 1'b0)    begin errors++; $display("FAIL blank_rd_en got %b want 0", obs_rd); end
      idle(4);
      k = 0; k657 = -1; klow = -1;
      for (int x = 650; x < 670; x++) begin
         cyc(x, 300, 0, 0);
         if (klow < 0 && obs_hs === 1'b0) klow = k;
         if (x == 657) k657 = k;
         k++;
      end
      idle(4);
      checks++;
      if (klow - k657 != 3) begin errors++; $display("FAIL hsync_latency got %0d want 3", klow - k657); end
   endtask

   task automatic test_step_ack();
      int n = 0;
      int base = exp_missed;
      cyc(0, 480, 0, 0);
      for (int i = 1; i <= 15; i++) begin cyc(780, 500, 0, i == 10); n += int'(obs_req); end
      cyc(0, 0, 0, 0); idle(1);
      checks += 2;
      if (n != 10) begin errors++; $display("FAIL step_req_cycles got %0d want 10", n); end
      if (obs_missed !== 8'(base)) begin errors++; $display("FAIL ack_missed got %0d want %0d", obs_missed, base); end
   endtask

   task automatic test_missed();
      int base = exp_missed;
      int frames_req = 0;
      for (int f = 0; f < 3; f++) begin
         cyc(0, 480, 0, 0); idle(1);
         frames_req += int'(obs_req);
         idle(4); cyc(0, 0, 0, 0); idle(2);
      end
      checks += 2;
      if (frames_req != 3) begin errors++; $display("FAIL req_each_frame got %0d want 3", frames_req); end
      if (obs_missed !== 8'(base + 3)) begin errors++; $display("FAIL missed_3 got %0d want %0d", obs_missed, base + 3); end
   endtask

   task automatic test_pause();
      int n = 0;
      cyc(0, 480, 1, 0);
      for (int i = 0; i < 5; i++) begin cyc(780, 500, 0, 0); n += int'(obs_req); end
      cyc(0, 0, 0, 0);
      checks++;
      if (n != 0) begin errors++; $display("FAIL paused_req got %0d want 0", n); end
      n = 0;
      cyc(0, 480, 0, 0);
      for (int i = 0; i < 5; i++) begin cyc(780, 500, 1, 0); n += int'(obs_req); end
      cyc(780, 500, 1, 1); cyc(0, 0, 0, 0); idle(1);
      checks++;
      if (n != 5) begin errors++; $display("FAIL pause_in_req got %0d want 5", n); end
   endtask

   task automatic test_ack_wrap();
      int base = exp_missed;
      cyc(0, 480, 0, 0); idle(3);
      cyc(0, 0, 0, 1); idle(1);
      checks += 2;
      if (obs_req !== 1'b0) begin errors++; $display("FAIL ackwrap_req got %b want 0", obs_req); end
      if (obs_missed !== 8'(base)) begin errors++; $display("FAIL ackwrap_missed got %0d want %0d", obs_missed, base); end
      cyc(0, 480, 0, 0); idle(1);
      checks++;
      if (obs_req !== 1'b1) begin errors++; $display("FAIL ackwrap_next_frame got %b want 1", obs_req); end
      cyc(780, 500, 0, 1); cyc(0, 0, 0, 0); idle(1);
   endtask

   task automatic test_random();
      idle(3);
      for (int i = 0; i < 4800; i++) mem[i] = bit'($urandom_range(0, 1));
      for (int i = 0; i < 2500; i++) begin
         int r = $urandom_range(0, 99);
         bit p = ($urandom_range(0, 3) == 0);
         bit a = ($urandom_range(0, 7) == 0);
         if (r < 3)      cyc(0, 480, p, a);
         else if (r < 6) cyc(0, 0, p, a);
         else            cyc($urandom_range(0, 799), $urandom_range(0, 524), p, a);
      end
      idle(3);
   endtask

   task automatic test_saturate();
      for (int f = 0; f < 260; f++) begin cyc(0, 480, 0, 0); cyc(0, 0, 0, 0); end
      idle(1);
      checks++;
      if (obs_missed !== 8'd255) begin errors++; $display("FAIL missed_saturate got %0d want 255", obs_missed); end
   endtask

   task automatic test_mid_reset();
      idle(3);
      mem[81] = 1; mem[0] = 1;
      cyc(0, 480, 0, 0);
      repeat (4) cyc(9, 9, 0, 0);
      #7;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midline");
      model_reset();
      @(negedge clk);
      counter_x = 10'd780; counter_y = 10'd500;
      h_sync_in = 1'b1; v_sync_in = 1'b1; disp_en_in = 1'b0; step_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);
      idle(5);
   endtask

   initial begin
      test_reset();
      test_live_cell();
      test_grid();
      test_blank_sync();
      test_step_ack();
      test_missed();
      test_pause();
      test_ack_wrap();
      test_random();
      test_saturate();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
